gfx_mask_scan: RTL and testbench

//   Serialises a WIDTH-bit lane/work mask into one index per cycle: the set bits,

---
 rtl/gfx_mask_scan.sv | 93 +++++++++
 tb/tb_gfx_mask_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_mask_scan.sv
`default_nettype none
// gfx_mask_scan: serialises the set bits of a mask into one index per beat, lowest first.
// Optional back-to-back mask acceptance via GFX_MASK_SCAN_B2B_EN.  Rev 1.0
module gfx_mask_scan #(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_mask,
   input  logic [TAG_WIDTH-1:0]     in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] out_index,
   output logic                     out_first,
   output logic                     out_last,
   output logic [TAG_WIDTH-1:0]     out_tag
);
   localparam int IW = $clog2(WIDTH);

   typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     rem, rem_nxt, rem_clr;
   logic [TAG_WIDTH-1:0] tag, tag_nxt;
   logic                 first, first_nxt;
   logic                 scan, last, in_hs, out_hs, load;
   logic [IW-1:0]        low_idx;

   assign scan    = (state == SCAN);
   assign rem_clr = rem & (rem - WIDTH'(1));
   assign last    = (rem_clr == '0);

   // Descending walk so the lowest set bit wins.
   always_comb begin
      low_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (rem[i]) low_idx = IW'(i);
   end

   // Outputs read zero outside SCAN so the idle/reset view is clean.
   assign out_valid = scan;
   assign out_index = scan ? low_idx : '0;
   assign out_first = scan & first;
   assign out_last  = scan & last;
   assign out_tag   = scan ? tag : '0;

`ifdef GFX_MASK_SCAN_B2B_EN
   assign in_ready = ~scan | (last & out_ready);
`else
   assign in_ready = ~scan;
`endif

   assign in_hs  = in_valid & in_ready;
   assign out_hs = scan & out_ready;
   assign load   = in_hs & (in_mask != '0);

   // A load coinciding with the final beat overrides the return to IDLE.
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      tag_nxt   = tag;
      first_nxt = first;
      if (out_hs) begin
         rem_nxt   = rem_clr;
         first_nxt = 1'b0;
         if (last) state_nxt = IDLE;
      end
      if (load) begin
         rem_nxt   = in_mask;
         tag_nxt   = in_tag;
         first_nxt = 1'b1;
         state_nxt = SCAN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         tag   <= '0;
         first <= 1'b0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         tag   <= tag_nxt;
         first <= first_nxt;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_gfx_mask_scan.sv
`default_nettype none
// tb_gfx_mask_scan: directed and random stimulus with an expected-beat queue.
module tb_gfx_mask_scan;
   localparam int WIDTH = 32;
   localparam int TW    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_mask = '0;
   logic [TW-1:0]    in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [4:0]       out_index;
   logic             out_first;
   logic             out_last;
   logic [TW-1:0]    out_tag;

   gfx_mask_scan #(.WIDTH(WIDTH), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .out_first(out_first), .out_last(out_last), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]    idx;
      logic          first;
      logic          last;
      logic [TW-1:0] tag;
   } beat_t;

   beat_t       sb[$];
   int          errors = 0;
   int          checks = 0;
   logic        in_hs = 1'b0;
   logic        stall_prev = 1'b0;
   logic [15:0] held = '0;
   int          beats, cycles;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic push_mask(input logic [WIDTH-1:0] m, input logic [TW-1:0] t);
      int total, seen;
      beat_t b;
      total = $countones(m);
      seen = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (m[i]) begin
            seen++;
            b.idx = 5'(i);
            b.first = (seen == 1);
            b.last = (seen == total);
            b.tag = t;
            sb.push_back(b);
         end
      end
   endtask

   // One clock: settle, check the beat/stall/accept, then advance past the edge.
   task automatic step();
      beat_t e;
      #1;
      in_hs = 1'b0;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", 64'({out_valid, out_index, out_first, out_last, out_tag}), 64'(held));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_beat", 64'(out_index), 64'hDEAD);
            else begin
               e = sb.pop_front();
               chk("index", 64'(out_index), 64'(e.idx));
               chk("first", 64'(out_first), 64'(e.first));
               chk("last", 64'(out_last), 64'(e.last));
               chk("tag", 64'(out_tag), 64'(e.tag));
            end
         end
         stall_prev = out_valid && !out_ready;
         held = {out_valid, out_index, out_first, out_last, out_tag};
         if (in_valid && in_ready) begin
            in_hs = 1'b1;
            push_mask(in_mask, in_tag);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] m, input logic [TW-1:0] t);
      int n;
      in_valid = 1'b1;
      in_mask = m;
      in_tag = t;
      n = 0;
      do begin
         step();
         n++;
      end while (!in_hs && n < 200);
      in_valid = 1'b0;
      if (!in_hs) chk("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      for (int c = 0; c < 500 && sb.size() != 0; c++) step();
      chk("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_index", 64'(out_index), 64'(0));
      chk("rst_first", 64'(out_first), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_tag", 64'(out_tag), 64'(0));
      rst = 1'b0;
      step();

      // 1: three beats on consecutive cycles after the accept
      out_ready = 1'b1;
      send(32'h0000_0091, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         chk("t1_valid", 64'(out_valid), 64'(1));
         step();
      end
      chk("t1_idle", 64'(out_valid), 64'(0));
      drain();

      // 2: top bit alone, then a zero mask
      send(32'h8000_0000, 8'hC3);
      chk("t2_valid", 64'(out_valid), 64'(1));
      drain();
      send(32'h0, 8'h11);
      chk("t2_zero_valid", 64'(out_valid), 64'(0));
      chk("t2_zero_ready", 64'(in_ready), 64'(1));
      step();

      // 3: all ones with random backpressure
      send(32'hFFFF_FFFF, 8'h77);
      for (int c = 0; c < 1000 && sb.size() != 0; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
      end
      chk("t3_drain", 64'(sb.size()), 64'(0));
      out_ready = 1'b1;
      step();

      // 4: two masks offered back-to-back
      send(32'h3, 8'h01);
      in_valid = 1'b1;
      in_mask = 32'h5;
      in_tag = 8'h02;
      beats = 0;
      cycles = 0;
      while (beats < 4 && cycles < 20) begin
         if (out_valid) beats++;
         cycles++;
         step();
         if (in_hs) in_valid = 1'b0;
      end
      in_valid = 1'b0;
`ifdef GFX_MASK_SCAN_B2B_EN
      chk("t4_cycles", 64'(cycles), 64'(4));
`else
      chk("t4_cycles", 64'(cycles), 64'(5));
`endif
      drain();

      // 5: reset in the middle of a scan
      send(32'h0000_00FF, 8'hAB);
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      out_ready = 1'b0;
      step();
      rst = 1'b0;
      sb.delete();
      chk("t5_valid", 64'(out_valid), 64'(0));
      chk("t5_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t5_no_stale", 64'(out_valid), 64'(0));
         step();
      end

      // 6: random sparse masks, random valid and backpressure
      beats = 0;
      cycles = 0;
      while (beats < 2000 && cycles < 60000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_mask = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            in_tag = 8'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycles++;
         step();
         if (in_hs) begin
            in_valid = 1'b0;
            beats++;
         end
      end
      chk("t6_masks", 64'(beats), 64'(2000));
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
